// File: rtl/tcp_passive_open.sv
// tcp_passive_open
//   Responder side of the TCP three-way handshake. Waits in LISTEN for a
//   client SYN, answers with SYN-ACK carrying the local ISN, retransmits the
//   SYN-ACK on timeout up to MAX_RETRY times, and moves to ESTABLISHED once a
//   correctly numbered ACK arrives. A peer RST abandons the handshake.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   listen       level, enables passive open
//   syn_in       strobe, SYN segment present
//   ack_in       strobe, ACK segment present
//   rst_in       strobe, peer RST segment present
//   seq_in       sequence field of the current segment
//   ack_num_in   acknowledgement field of the current segment
//   syn_ack_out  strobe, transmit SYN-ACK
//   seq_out      local sequence number
//   ack_out      acknowledgement number (peer ISN + 1)
//   established  level, high only in ESTABLISHED
//   abort        strobe, handshake abandoned
//   state_out    current state encoding
module tcp_passive_open #(
    parameter int          SEQ_W     = 32,
    parameter logic [31:0] ISN       = 32'h0000_1000,
    parameter int          TIMEOUT   = 16,
    parameter int          MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             listen,
    input  logic             syn_in,
    input  logic             ack_in,
    input  logic             rst_in,
    input  logic [SEQ_W-1:0] seq_in,
    input  logic [SEQ_W-1:0] ack_num_in,
    output logic             syn_ack_out,
    output logic [SEQ_W-1:0] seq_out,
    output logic [SEQ_W-1:0] ack_out,
    output logic             established,
    output logic             abort,
    output logic [1:0]       state_out
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [SEQ_W-1:0] ISN_L    = SEQ_W'(ISN);
    localparam logic [SEQ_W-1:0] ISN_P1   = ISN_L + SEQ_W'(1);
    // Timer counts down to zero; loading TIMEOUT-1 makes the expiry fall
    // exactly TIMEOUT cycles after the SYN-ACK that loaded it.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        CLOSED      = 2'b00,
        LISTEN      = 2'b01,
        SYN_RCVD    = 2'b10,
        ESTABLISHED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   irs_q, irs_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [SEQ_W-1:0]   ack_q, ack_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               syn_ack_q, syn_ack_d;
    logic               abort_q, abort_d;

    logic               ack_ok;
    logic               dup_syn;
    logic               expired;

    assign ack_ok  = ack_in && (ack_num_in == ISN_P1) && (seq_in == irs_q + SEQ_W'(1));
    assign dup_syn = syn_in && (seq_in == irs_q);
    assign expired = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        irs_d     = irs_q;
        seq_d     = seq_q;
        ack_d     = ack_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        syn_ack_d = 1'b0;
        abort_d   = 1'b0;

        case (state_q)
            CLOSED: begin
                if (listen) state_d = LISTEN;
            end
            LISTEN: begin
                if (!listen) begin
                    state_d = CLOSED;
                end else if (syn_in) begin
                    state_d   = SYN_RCVD;
                    irs_d     = seq_in;
                    ack_d     = seq_in + SEQ_W'(1);
                    seq_d     = ISN_L;
                    syn_ack_d = 1'b1;
                    timer_d   = TMR_LOAD;
                    retry_d   = '0;
                end
            end
            SYN_RCVD: begin
                // Priority: RST, valid ACK, duplicate SYN, timer expiry.
                if (rst_in) begin
                    abort_d = 1'b1;
                    state_d = listen ? LISTEN : CLOSED;
                end else if (ack_ok) begin
                    state_d = ESTABLISHED;
                    seq_d   = ISN_P1;
                end else if (dup_syn) begin
                    syn_ack_d = 1'b1;
                    timer_d   = TMR_LOAD;
                end else if (expired) begin
                    if (retry_q == RTY_MAX) begin
                        abort_d = 1'b1;
                        state_d = listen ? LISTEN : CLOSED;
                    end else begin
                        syn_ack_d = 1'b1;
                        retry_d   = retry_q + RTY_W'(1);
                        timer_d   = TMR_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ESTABLISHED: begin
                if (rst_in) state_d = CLOSED;
            end
            default: state_d = CLOSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= CLOSED;
            irs_q     <= '0;
            seq_q     <= '0;
            ack_q     <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            syn_ack_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            irs_q     <= irs_d;
            seq_q     <= seq_d;
            ack_q     <= ack_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            syn_ack_q <= syn_ack_d;
            abort_q   <= abort_d;
        end
    end

    assign syn_ack_out = syn_ack_q;
    assign seq_out     = seq_q;
    assign ack_out     = ack_q;
    assign abort       = abort_q;
    assign established = (state_q == ESTABLISHED);
    assign state_out   = state_q;

endmodule

// File: tb/tb_tcp_passive_open.sv
// Testbench for tcp_passive_open. Each step drives one cycle of inputs and
// pushes the outputs expected after the next rising edge into a scoreboard
// queue; after the edge the entry is popped and compared field by field.
module tb_tcp_passive_open;

    localparam logic [1:0] CL = 2'b00;
    localparam logic [1:0] LS = 2'b01;
    localparam logic [1:0] SR = 2'b10;
    localparam logic [1:0] ES = 2'b11;

    logic        clk;
    logic        reset;
    logic        listen;
    logic        syn_in;
    logic        ack_in;
    logic        rst_in;
    logic [31:0] seq_in;
    logic [31:0] ack_num_in;
    logic        syn_ack_out;
    logic [31:0] seq_out;
    logic [31:0] ack_out;
    logic        established;
    logic        abort;
    logic [1:0]  state_out;

    typedef struct {
        logic [1:0]  st;
        logic        sa;
        logic        ab;
        logic        est;
        logic [31:0] seq;
        logic [31:0] ack;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] e_seq  = 32'h0;
    logic [31:0] e_ack  = 32'h0;

    tcp_passive_open #(
        .SEQ_W     (32),
        .ISN       (32'h0000_1000),
        .TIMEOUT   (16),
        .MAX_RETRY (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .listen      (listen),
        .syn_in      (syn_in),
        .ack_in      (ack_in),
        .rst_in      (rst_in),
        .seq_in      (seq_in),
        .ack_num_in  (ack_num_in),
        .syn_ack_out (syn_ack_out),
        .seq_out     (seq_out),
        .ack_out     (ack_out),
        .established (established),
        .abort       (abort),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic l, input logic s, input logic a,
                        input logic r, input logic [31:0] sq, input logic [31:0] an,
                        input logic [1:0] st, input logic sa, input logic ab);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset = rn; listen = l; syn_in = s; ack_in = a; rst_in = r;
        seq_in = sq; ack_num_in = an;
        e.st = st; e.sa = sa; e.ab = ab; e.est = (st == ES);
        e.seq = e_seq; e.ack = e_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            g = sb.pop_front();
            check("state",       64'(state_out),   64'(g.st));
            check("syn_ack_out", 64'(syn_ack_out), 64'(g.sa));
            check("abort",       64'(abort),       64'(g.ab));
            check("established", 64'(established), 64'(g.est));
            check("seq_out",     64'(seq_out),     64'(g.seq));
            check("ack_out",     64'(ack_out),     64'(g.ack));
        end
    endtask

    task automatic idle(input logic l, input logic [1:0] st);
        step(1'b1, l, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, st, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; listen = 1'b0; syn_in = 1'b0; ack_in = 1'b0; rst_in = 1'b0;
        seq_in = '0; ack_num_in = '0;

        // Reset, then strobes ignored in CLOSED
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CL, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, CL, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h64, 32'h0, CL, 1'b0, 1'b0);
        idle(1'b1, LS);

        // Basic handshake
        e_seq = 32'h1000; e_ack = 32'h65;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h64, 32'h0, SR, 1'b1, 1'b0);
        e_seq = 32'h1001;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h65, 32'h1001, ES, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h64, 32'h1001, ES, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, CL, 1'b0, 1'b0);
        idle(1'b1, LS);

        // Bad ACK then retransmits and retry exhaustion
        e_seq = 32'h1000; e_ack = 32'h65;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h64, 32'h0, SR, 1'b1, 1'b0);
        for (int k = 1; k <= 64; k++) begin
            if (k == 1)
                step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h65, 32'h1002, SR, 1'b0, 1'b0);
            else
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (k == 64) ? LS : SR,
                     (k % 16 == 0) && (k < 64), k == 64);
        end

        // Wrap-around of the peer sequence number
        e_seq = 32'h1000; e_ack = 32'h0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, SR, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1001, SR, 1'b0, 1'b0);
        e_seq = 32'h1001;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1001, ES, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, CL, 1'b0, 1'b0);
        idle(1'b1, LS);

        // RST and valid ACK in the same cycle
        e_seq = 32'h1000; e_ack = 32'h201;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, SR, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h201, 32'h1001, LS, 1'b0, 1'b1);

        // Valid ACK in the expiry cycle
        e_ack = 32'h301;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, SR, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) idle(1'b1, SR);
        e_seq = 32'h1001;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h301, 32'h1001, ES, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, CL, 1'b0, 1'b0);
        idle(1'b1, LS);

        // Duplicate SYN, foreign SYN, listen drop, reset just before expiry
        e_seq = 32'h1000; e_ack = 32'h401;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, SR, 1'b1, 1'b0);
        for (int k = 1; k <= 38; k++) begin
            if (k >= 37) begin
                e_seq = 32'h0; e_ack = 32'h0;
            end
            if (k == 6)
                step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, SR, 1'b1, 1'b0);
            else if (k == 7)
                step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h999, 32'h0, SR, 1'b0, 1'b0);
            else if (k == 37)
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, CL, 1'b0, 1'b0);
            else
                step(1'b1, k < 23, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (k == 38) ? CL : SR,
                     k == 22, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_passive_open.md
# tcp_passive_open

Passive-open (responder) end of the TCP three-way handshake: listens for a client SYN, answers with SYN-ACK carrying its own initial sequence number, and validates the client's final ACK before declaring the connection established. It sits opposite the client initiator in the handshake top level. It adds SYN-ACK retransmission on timeout, a bounded retry count and peer-RST handling.

## Interface
- SEQ_W, 32: width of sequence/acknowledgement numbers
- ISN, 32'h0000_1000: local initial sequence number, truncated to SEQ_W
- TIMEOUT, 16: cycles between SYN-ACK transmissions while awaiting ACK (≥2)
- MAX_RETRY, 3: SYN-ACK retransmissions allowed before abort (≥0)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset
- listen  in  1  level; enables passive open
- syn_in  in  1  one-cycle strobe: SYN segment present
- ack_in  in  1  one-cycle strobe: ACK segment present
- rst_in  in  1  one-cycle strobe: peer RST segment present
- seq_in  in  SEQ_W  sequence field of the current segment
- ack_num_in  in  SEQ_W  acknowledgement field of the current segment
- syn_ack_out  out  1  one-cycle strobe: transmit SYN-ACK
- seq_out  out  SEQ_W  local sequence number
- ack_out  out  SEQ_W  acknowledgement number (peer ISN + 1)
- established  out  1  level; high only in ESTABLISHED
- abort  out  1  one-cycle strobe: handshake abandoned
- state_out  out  2  current state encoding

## Operation
- States: CLOSED=2'b00, LISTEN=2'b01, SYN_RCVD=2'b10, ESTABLISHED=2'b11.
- Reset (reset=0 at a clock edge): state CLOSED; all outputs 0; internal irs, timer and retry count cleared.
- CLOSED: listen=1 → LISTEN. All strobes are ignored.
- LISTEN: listen=0 → CLOSED. syn_in=1 → SYN_RCVD. On that transition: irs←seq_in, ack_out←seq_in+1 mod 2^SEQ_W, seq_out←ISN, syn_ack_out pulsed, timer loaded, retry←0. ack_in and rst_in are ignored.
- SYN_RCVD, priority rst_in > ack_in > syn_in > timeout:
  - rst_in → abort pulsed. Next state is LISTEN if listen=1, else CLOSED.
  - ack_in with ack_num_in==ISN+1 and seq_in==irs+1 (both mod 2^SEQ_W) → ESTABLISHED, seq_out←ISN+1. An ack_in failing either check is dropped; the timer keeps running.
  - syn_in with seq_in==irs (duplicate SYN) → syn_ack_out pulsed, timer reloaded, retry unchanged. syn_in with a different seq_in is dropped.
  - Timer expiry with retry<MAX_RETRY → syn_ack_out pulsed, retry+1, timer reloaded.
  - Timer expiry with retry==MAX_RETRY → abort pulsed. Next state is LISTEN if listen=1, else CLOSED.
  - listen deasserting does not abandon SYN_RCVD.
- ESTABLISHED: established=1. rst_in → CLOSED, established cleared, seq_out/ack_out hold their values. syn_in, ack_in and listen are ignored.
- Leaving to LISTEN or CLOSED keeps seq_out/ack_out at their last values; only reset clears them.
- Arithmetic is modulo 2^SEQ_W: seq_in all-ones gives ack_out=0, and a matching ACK then needs seq_in==0.

## Timing
- All outputs are registered. Inputs sampled at edge N produce output changes visible after edge N.
- syn_ack_out is high exactly the one cycle after the sampled syn_in, duplicate SYN or expiry. It is never high two consecutive cycles.
- Retransmission: the next syn_ack_out rises exactly TIMEOUT cycles after the previous syn_ack_out rise, with no valid ACK in between.
- Abort on exhaustion: abort rises TIMEOUT cycles after the final (MAX_RETRY-th) retransmit. syn_ack_out is not asserted in that cycle.
- A valid ACK sampled in the expiry cycle wins: ESTABLISHED, no retransmit, no abort.
- established rises one cycle after the valid ACK is sampled. state_out changes in the same cycle.
- Reset asserted in any state (including mid-retransmit) forces CLOSED at the next edge and suppresses any pending strobe.

## Test plan
- Basic handshake: listen=1, syn_in with seq_in=0x0000_0064, then valid ACK (seq_in=0x65, ack_num_in=0x1001) → syn_ack_out one cycle after SYN; ack_out=0x65; seq_out=0x1000, then 0x1001; established high, state_out=2'b11.
- Bad ACK: in SYN_RCVD, ack_in with ack_num_in=0x1002 → no state change; retransmit still fires TIMEOUT=16 cycles after the first SYN-ACK.
- Retry exhaustion: SYN then silence, MAX_RETRY=3 → syn_ack_out at T, T+16, T+32, T+48; abort at T+64; state_out=2'b01 with listen held high.
- Wrap-around: syn_in with seq_in=0xFFFF_FFFF → ack_out=0x0000_0000; ACK with seq_in=0, ack_num_in=0x1001 → established.
- Simultaneous events: rst_in and valid ACK in the same cycle → abort pulsed, LISTEN, established stays 0. Valid ACK in the expiry cycle → ESTABLISHED, no syn_ack_out.
- Reset mid-operation: reset=0 during SYN_RCVD one cycle before expiry → state_out=2'b00, all outputs 0, no syn_ack_out.
